// File: rtl/cipher_pkg.sv
// Shared types and constants for the word-wide LFSR stream cipher.
// Holds the FSM state encoding, the combiner selection and the default tap masks.
package cipher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    FILL,
    FULL
  } state_t;

  localparam int MODE_XOR   = 0;
  localparam int MODE_GEFFE = 1;

  localparam logic [4:0] TAPS1_DEF = 5'b10100;
  localparam logic [6:0] TAPS2_DEF = 7'b1100000;
  localparam logic [8:0] TAPS3_DEF = 9'b100010000;

  function automatic logic combine(input int mode, input logic x1, input logic x2, input logic x3);
    if (mode == MODE_GEFFE) return (x1 & x2) ^ (~x1 & x3);
    return x1 ^ x2 ^ x3;
  endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR with seed load, zero-seed substitution and a per-load error flag.
// The output bit is the MSB before the shift; the feedback enters at bit 0.
module lfsr_fib
  import cipher_pkg::*;
#(
  parameter int           W    = 5,
  parameter logic [W-1:0] TAPS = TAPS1_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic         out_bit,
  output logic         seed_err
);

  logic [W-1:0] s;
  logic [W-1:0] s_next;
  logic         fb;

  assign fb      = ^(s & TAPS);
  assign out_bit = s[W-1];

  generate
    if (W == 1) begin : g_narrow
      assign s_next = fb;
    end else begin : g_wide
      assign s_next = {s[W-2:0], fb};
    end
  endgenerate

  // An all-zero seed would lock the register up, so it is replaced by 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s        <= '0;
      seed_err <= 1'b0;
    end else if (load) begin
      s        <= (seed == '0) ? W'(1) : seed;
      seed_err <= (seed == '0);
    end else if (step) begin
      s <= s_next;
    end
  end

endmodule

// File: rtl/stream_cipher_core.sv
// Word-wide stream cipher: three LFSRs feed a combiner that fills a keystream word,
// which is XORed with each accepted data word behind valid/ready handshakes.
module stream_cipher_core
  import cipher_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter int              L1_W   = 5,
  parameter int              L2_W   = 7,
  parameter int              L3_W   = 9,
  parameter logic [L1_W-1:0] TAPS1  = TAPS1_DEF,
  parameter logic [L2_W-1:0] TAPS2  = TAPS2_DEF,
  parameter logic [L3_W-1:0] TAPS3  = TAPS3_DEF,
  parameter int              MODE   = MODE_XOR,
  parameter int              WARMUP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [L1_W-1:0]   key1,
  input  logic [L2_W-1:0]   key2,
  input  logic [L3_W-1:0]   key3,
  input  logic              key_load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              key_err
);

  localparam int CNT_MAX = (DATA_W > WARMUP) ? DATA_W : WARMUP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] ks_word;
  logic [DATA_W-1:0] ks_next;
  logic              x1, x2, x3;
  logic              e1, e2, e3;
  logic              ks_bit;
  logic              step;
  logic              accept;
  logic              drain;

  assign step     = !key_load && ((state == WARM) || (state == FILL));
  assign ks_bit   = combine(MODE, x1, x2, x3);
  assign in_ready = (state == FULL) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !key_load;
  assign drain    = out_valid && out_ready;
  assign key_err  = e1 | e2 | e3;

  generate
    if (DATA_W == 1) begin : g_ks_narrow
      assign ks_next = ks_bit;
    end else begin : g_ks_wide
      assign ks_next = {ks_word[DATA_W-2:0], ks_bit};
    end
  endgenerate

  lfsr_fib #(.W(L1_W), .TAPS(TAPS1)) u_lfsr1 (
    .clk(clk), .reset(reset), .load(key_load), .seed(key1),
    .step(step), .out_bit(x1), .seed_err(e1)
  );

  lfsr_fib #(.W(L2_W), .TAPS(TAPS2)) u_lfsr2 (
    .clk(clk), .reset(reset), .load(key_load), .seed(key2),
    .step(step), .out_bit(x2), .seed_err(e2)
  );

  lfsr_fib #(.W(L3_W), .TAPS(TAPS3)) u_lfsr3 (
    .clk(clk), .reset(reset), .load(key_load), .seed(key3),
    .step(step), .out_bit(x3), .seed_err(e3)
  );

  // A rekey overrides everything, including a handshake in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ks_word   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (key_load) begin
      state     <= (WARMUP > 0) ? WARM : FILL;
      cnt       <= '0;
      ks_word   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ ks_word;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: ;
        WARM: begin
          if (int'(cnt) == WARMUP - 1) begin
            state <= FILL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FILL: begin
          ks_word <= ks_next;
          if (int'(cnt) == DATA_W - 1) begin
            state <= FULL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FULL: begin
          if (accept) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
